// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares a one-byte flag/data transmit mailbox between
// N_REQ byte producers. A new byte is issued only after the previous one was
// consumed. A watchdog force-clears the mailbox if the consumer stalls.
// Build option: define UART_ARB_FIXED_PRIO_EN for fixed priority (lowest
// index wins); the default build arbitrates round-robin.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DW      = 8,
  parameter int unsigned TIMEOUT = 50000,
  parameter int unsigned TO_W    = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    ack,
  input  logic                buf_flag,
  output logic                buf_set,
  output logic                buf_clr,
  output logic [DW-1:0]       buf_din,
  output logic [2:0]          grant_id,
  output logic                busy,
  output logic                err,
  input  logic                err_clr
);

  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WAIT  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t              state, state_d;
  logic [TO_W-1:0]     cnt, cnt_d;
  logic                to_hit;

  logic                win_found;
  int unsigned         win_idx;

  logic [N_REQ-1:0]    ack_d;
  logic                buf_set_d;
  logic                buf_clr_d;
  logic [DW-1:0]       buf_din_d;
  logic [IDX_W-1:0]    grant_id_d;
  logic                busy_d;
  logic                err_d;

`ifndef UART_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]    rr_ptr, rr_ptr_d;
  int unsigned         cand;
`endif

  assign to_hit = (cnt == TO_W'(TIMEOUT - 1));

  // Winner selection among the current requests
`ifdef UART_ARB_FIXED_PRIO_EN
  always_comb begin
    win_found = 1'b0;
    win_idx   = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!win_found && req[i]) begin
        win_found = 1'b1;
        win_idx   = i;
      end
    end
  end
`else
  always_comb begin
    win_found = 1'b0;
    win_idx   = 0;
    cand      = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = 32'(rr_ptr) + 1 + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (!buf_flag && win_found) state_d = LOAD;
      LOAD:  state_d = WAIT;
      WAIT: begin
        if (!buf_flag)   state_d = IDLE;
        else if (to_hit) state_d = FLUSH;
      end
      FLUSH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; all registered below
  always_comb begin
    ack_d      = '0;
    buf_set_d  = 1'b0;
    buf_clr_d  = 1'b0;
    buf_din_d  = buf_din;
    grant_id_d = grant_id;
    cnt_d      = cnt;
    err_d      = err & ~err_clr;
`ifndef UART_ARB_FIXED_PRIO_EN
    rr_ptr_d   = rr_ptr;
`endif
    case (state)
      IDLE: begin
        if (!buf_flag && win_found) begin
          buf_set_d  = 1'b1;
          ack_d      = N_REQ'(1) << win_idx;
          buf_din_d  = req_data[win_idx*DW +: DW];
          grant_id_d = IDX_W'(win_idx);
`ifndef UART_ARB_FIXED_PRIO_EN
          rr_ptr_d   = IDX_W'(win_idx);
`endif
        end
      end
      LOAD: cnt_d = '0;
      WAIT: begin
        if (buf_flag) begin
          if (to_hit) begin
            buf_clr_d = 1'b1;
            err_d     = 1'b1;
          end else begin
            cnt_d = cnt + TO_W'(1);
          end
        end
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Output and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      ack      <= '0;
      buf_set  <= 1'b0;
      buf_clr  <= 1'b0;
      buf_din  <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
      cnt      <= '0;
`ifndef UART_ARB_FIXED_PRIO_EN
      rr_ptr   <= IDX_W'(N_REQ - 1);
`endif
    end else begin
      ack      <= ack_d;
      buf_set  <= buf_set_d;
      buf_clr  <= buf_clr_d;
      buf_din  <= buf_din_d;
      grant_id <= grant_id_d;
      busy     <= busy_d;
      err      <= err_d;
      cnt      <= cnt_d;
`ifndef UART_ARB_FIXED_PRIO_EN
      rr_ptr   <= rr_ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: mailbox + consumer model, grant scoreboard.
module tb_uart_tx_arbiter;

  localparam int unsigned N_REQ   = 4;
  localparam int unsigned DW      = 8;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned TO_W    = 16;

  logic                clock = 1'b0;
  logic                reset;
  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    ack;
  logic                buf_flag;
  logic                buf_set;
  logic                buf_clr;
  logic [DW-1:0]       buf_din;
  logic [2:0]          grant_id;
  logic                busy;
  logic                err;
  logic                err_clr;

  uart_tx_arbiter #(.N_REQ(N_REQ), .DW(DW), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clock(clock), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
    .buf_flag(buf_flag), .buf_set(buf_set), .buf_clr(buf_clr), .buf_din(buf_din),
    .grant_id(grant_id), .busy(busy), .err(err), .err_clr(err_clr)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_set_cyc = 0;

  typedef struct {
    int id;
    int data;
    int gap;
  } exp_t;
  exp_t sb[$];

  // Mailbox and consumer model
  logic mb_flag;
  logic force_hi;
  logic cons_en;
  int   cons_delay;
  int   age;
  logic cons_clr;

  assign cons_clr = cons_en && mb_flag && (age >= cons_delay);
  assign buf_flag = mb_flag | force_hi;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) begin
      mb_flag <= 1'b0;
      age     <= 0;
    end else begin
      if (buf_set)                   mb_flag <= 1'b1;
      else if (buf_clr || cons_clr)  mb_flag <= 1'b0;
      age <= mb_flag ? age + 1 : 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Grant monitor: pops the scoreboard on every buf_set pulse
  always @(negedge clock) begin
    if (!reset && buf_set) begin
      if (sb.size() == 0) begin
        check("unexp_set", 32'(buf_set), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("grant_id", 32'(grant_id), 32'(e.id));
        check("ack", 32'(ack), 32'd1 << e.id);
        check("buf_din", 32'(buf_din), 32'(e.data));
        if (e.gap >= 0) check("grant_gap", 32'(cyc - last_set_cyc), 32'(e.gap));
      end
      last_set_cyc = cyc;
    end
    if (!reset && buf_clr) check("set_clr_excl", 32'(buf_set), 32'd0);
  end

  task automatic push(input int id, input int data, input int gap);
    exp_t e;
    e.id = id; e.data = data; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; force_hi = 1'b0; err_clr = 1'b0;
    cons_en = 1'b1; cons_delay = 0;
    sb.delete();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Wait (bounded) until every expected grant has been observed
  task automatic wait_grants(input int max_cyc);
    int n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      @(posedge clock); #1;
      n++;
    end
    if (sb.size() != 0) begin
      check("grant_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_ack"},      32'(ack),      32'd0);
    check({pfx, "_buf_set"},  32'(buf_set),  32'd0);
    check({pfx, "_buf_clr"},  32'(buf_clr),  32'd0);
    check({pfx, "_buf_din"},  32'(buf_din),  32'd0);
    check({pfx, "_grant_id"}, 32'(grant_id), 32'd0);
    check({pfx, "_busy"},     32'(busy),     32'd0);
    check({pfx, "_err"},      32'(err),      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    int s2;
    int d;
    reset = 1'b1; req = '0; req_data = '0; err_clr = 1'b0;
    force_hi = 1'b0; cons_en = 1'b1; cons_delay = 0;

    // Reset state
    do_reset();
    @(negedge clock);
    check_reset_outputs("rst");

    // Single requester, consumer clears 2 cycles after flag rises
    cons_delay = 2;
    @(posedge clock); #1;
    req_data[0 +: 8] = 8'h41;
    req = 4'b0001;
    push(0, 'h41, -1);
    @(posedge clock);
    @(negedge clock);
    check("single_set_t1", 32'(buf_set), 32'd1);
    @(posedge clock); #1;
    req = 4'b0000;
    n = 0;
    while (mb_flag && n < 20) begin @(negedge clock); n++; end
    check("single_flag_drop", 32'(mb_flag), 32'd0);
    check("busy_after_clear", 32'(busy), 32'd1);
    @(negedge clock);
    check("busy_fall", 32'(busy), 32'd0);

    // All four requesting continuously, consumer clears immediately
    do_reset();
    cons_delay = 0;
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'(8'h10 + i);
    for (int k = 0; k < 5; k++) begin
`ifdef UART_ARB_FIXED_PRIO_EN
      push(0, 'h10, (k == 0) ? -1 : 4);
`else
      push(k % 4, 'h10 + (k % 4), (k == 0) ? -1 : 4);
`endif
    end
    req = 4'b1111;
    wait_grants(60);
    req = 4'b0000;
    repeat (6) @(posedge clock);

    // Stalled consumer: watchdog forced clear
    do_reset();
    cons_en = 1'b0;
    req_data[0 +: 8] = 8'h55;
    req_data[8 +: 8] = 8'h22;
    push(0, 'h55, -1);
    req = 4'b0001;
    wait_grants(10);
    req = 4'b0010;
    push(1, 'h22, 11);
    n = 0;
    do begin @(negedge clock); n++; end while (!buf_clr && n < 30);
    check("wd_clr_seen", 32'(buf_clr), 32'd1);
    check("wd_clr_delay", 32'(cyc - last_set_cyc), 32'(TIMEOUT + 1));
    check("wd_err", 32'(err), 32'd1);
    wait_grants(10);
    req = 4'b0000;

    // err_clr alone, then err_clr coinciding with a watchdog fire
    s2 = last_set_cyc;
    while (cyc < s2 + 2) begin @(posedge clock); #1; end
    err_clr = 1'b1;
    @(posedge clock); #1;
    err_clr = 1'b0;
    @(negedge clock);
    check("err_cleared", 32'(err), 32'd0);
    while (cyc < s2 + 8) begin @(posedge clock); #1; end
    err_clr = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    check("wd2_clr", 32'(buf_clr), 32'd1);
    check("err_set_wins", 32'(err), 32'd1);
    @(posedge clock); #1;
    err_clr = 1'b0;
    @(negedge clock);
    check("err_clr_alone", 32'(err), 32'd0);
    check("wd2_clr_fall", 32'(buf_clr), 32'd0);

    // Reset during WAIT with req[2] pending
    do_reset();
    cons_en = 1'b0;
    req_data[0 +: 8]  = 8'h77;
    req_data[16 +: 8] = 8'h33;
    push(0, 'h77, -1);
    req = 4'b0001;
    wait_grants(10);
    @(posedge clock); #1;
    req = 4'b0100;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_reset_outputs("midrst");
    cons_en = 1'b1;
    push(2, 'h33, -1);
    @(posedge clock); #1;
    reset = 1'b0;
    wait_grants(10);
    req = 4'b0000;
    repeat (6) @(posedge clock);

    // Foreign writer holds the flag in IDLE
    do_reset();
    req_data[8 +: 8] = 8'h5A;
    force_hi = 1'b1;
    req = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("hold_no_set", 32'(buf_set), 32'd0);
    end
    push(1, 'h5A, -1);
    @(posedge clock); #1;
    force_hi = 1'b0;
    d = cyc;
    @(negedge clock);
    check("drop_no_set_yet", 32'(buf_set), 32'd0);
    @(negedge clock);
    check("drop_set", 32'(buf_set), 32'd1);
    check("drop_set_cycle", 32'(cyc - d), 32'd1);
    wait_grants(10);
    req = 4'b0000;
    repeat (6) @(posedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single one-byte flag/data transmit mailbox between up to `N_REQ` byte producers, e.g. the debug unit, register dump and status reporter. It drives the mailbox's `set_flag`, `clr_flag` and `din` inputs and watches its `flag` output. It issues a new byte only after the UART side has consumed the previous one. A watchdog force-clears the mailbox if the consumer stalls.

## Interface
- `N_REQ`, default 4: number of requesters; range 2..8.
- `DW`, default 8: byte width, matching the mailbox.
- `TIMEOUT`, default 50000: WAIT cycles before forced clear; must be ≥2.
- `TO_W`, default 16: watchdog counter width; 2^TO_W must exceed `TIMEOUT`.
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `req`  in  N_REQ  request per requester. Held with data until ack.
- `req_data`  in  N_REQ*DW  byte of requester i on bits [i*DW +: DW].
- `ack`  out  N_REQ  one-cycle pulse: byte of requester i taken.
- `buf_flag`  in  1  mailbox `flag`: 1 = byte pending in mailbox.
- `buf_set`  out  1  to mailbox `set_flag`; one-cycle pulse.
- `buf_clr`  out  1  to mailbox `clr_flag`; watchdog forced clear only.
- `buf_din`  out  DW  to mailbox `din`; valid while `buf_set`=1.
- `grant_id`  out  3  index of last granted requester.
- `busy`  out  1  1 in any state other than IDLE.
- `err`  out  1  sticky watchdog-fired flag.
- `err_clr`  in  1  clears `err`.

## Operation
- Reset values:
  - `ack`=0, `buf_set`=0, `buf_clr`=0, `buf_din`=0, `grant_id`=0, `busy`=0, `err`=0.
  - State = IDLE; rr pointer = N_REQ-1, so requester 0 wins first; watchdog count = 0.
- All outputs are registered.
- States:
  - IDLE: if `buf_flag`=0 and `|req`:
    - Pick the winner W = first set `req` bit searching from pointer+1 upward, wrapping modulo N_REQ.
    - Register `buf_din`=req_data[W], `buf_set`=1, `ack[W]`=1, `grant_id`=W, pointer=W.
    - Go to LOAD.
  - IDLE otherwise: stay. If `buf_flag`=1 in IDLE (foreign writer), wait.
  - LOAD: the set pulse is visible for this one cycle. Clear `buf_set`, `ack` and count. Go to WAIT unconditionally.
  - WAIT: mailbox now holds the byte.
    - If `buf_flag`=0, go to IDLE.
    - Otherwise increment count. When count = TIMEOUT-1, register `buf_clr`=1 and `err`=1, then go to FLUSH.
  - FLUSH: `buf_clr` is high this cycle. Clear it and go to IDLE. The mailbox flag is 0 on entry to IDLE.
- Requesters not granted keep `req` asserted. No request is ever dropped; starvation is bounded to N_REQ-1 grants.
- A requester that deasserts `req` before ack simply loses its turn; no error.
- `err_clr` and a watchdog fire in the same cycle: set wins, so `err`=1.
- Reset mid-operation (any state) returns everything to reset values next edge. Any in-flight byte is abandoned without ack. The mailbox shares `reset`.
- `buf_set` and `buf_clr` are never high in the same cycle.

## Timing
- Request to mailbox write:
  - `req` sampled in IDLE at edge t.
  - `buf_set`/`ack` high during cycle t+1.
  - Mailbox `buf_flag`=1 from t+2.
- Minimum grant spacing: 4 cycles (IDLE, LOAD, WAIT with consumer clearing immediately, IDLE).
- After the consumer clears at edge c, the arbiter returns to IDLE at c+1 and can pulse `buf_set` again at c+2.
- Watchdog: `buf_clr` high exactly TIMEOUT+1 cycles after the LOAD cycle if `buf_flag` stays 1.
- Latency from IDLE with `buf_flag`=1 is unbounded until the flag drops. No watchdog runs in IDLE.

## Configuration
- `UART_ARB_FIXED_PRIO_EN` defined: fixed priority.
  - Lowest index set in `req` always wins.
  - The rr pointer is not implemented; `grant_id` still reports the winner.
- Undefined (default): round-robin as described above.

## Test plan
- Single requester: `req`=0001, data 0x41, consumer clears 2 cycles after flag rises.
  - `buf_set`/`ack[0]` pulse at t+1 with `buf_din`=0x41.
  - `busy` falls 1 cycle after the flag clears.
- All four requesting continuously with data 0x10..0x13, consumer clears immediately.
  - Grant order 0,1,2,3,0.
  - Grants spaced 4 cycles.
  - `UART_ARB_FIXED_PRIO_EN` build grants 0 every time.
- Stalled consumer with `TIMEOUT`=8, flag never cleared by the consumer.
  - `buf_clr` pulses 9 cycles after LOAD.
  - `err`=1; next grant 2 cycles later.
- `err_clr` asserted in the same cycle as a watchdog fire.
  - `err` stays 1.
  - `err_clr` alone on the next cycle gives `err`=0.
- `reset` asserted during WAIT:
  - All outputs return to reset values next edge.
  - Pending `req[2]` is granted first after reset only if `req[0]` and `req[1]` are low.
- `buf_flag` forced high in IDLE with `req`=0010:
  - No `buf_set` while flag=1.
  - Grant occurs 1 cycle after flag drops.
